// File: rtl/alu_pkg.sv
// Shared decode constants for the ALU issue path.
// Holds MIPS opcode/funct encodings, the one-hot op index enumeration
// and a helper that turns an op index into its one-hot select vector.
package alu_pkg;

    localparam int NUM_OPS = 14;

    // Primary opcodes
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SLA  = 6'h01;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_MUL  = 6'h18;
    localparam logic [5:0] FN_DIV  = 6'h1A;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;

    // Bit position of each op inside the one-hot select vector
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_ADDU = 4'd2,
        OP_SUBU = 4'd3,
        OP_MUL  = 4'd4,
        OP_DIV  = 4'd5,
        OP_AND  = 4'd6,
        OP_OR   = 4'd7,
        OP_XOR  = 4'd8,
        OP_NOR  = 4'd9,
        OP_SRL  = 4'd10,
        OP_SLL  = 4'd11,
        OP_SRA  = 4'd12,
        OP_SLA  = 4'd13
    } op_idx_e;

    function automatic logic [NUM_OPS-1:0] op_onehot(input op_idx_e idx);
        logic [NUM_OPS-1:0] v;
        v = {{(NUM_OPS-1){1'b0}}, 1'b1} << idx;
        return v;
    endfunction

endpackage

// File: rtl/alu_issue_decoder.sv
// Purely combinational MIPS decode for the ALU issue stage.
// Ports:
//   instr, rs_data, rt_data  : instruction word and its source operands
//   legal                    : instruction maps to a supported ALU op
//   op_sel                   : one-hot op select (all zero when illegal)
//   a, b, c                  : ALU operands, c is the shift amount
//   dest                     : writeback register index
//   div_by_zero              : op is DIV with a zero divisor
module alu_issue_decoder
    import alu_pkg::*;
(
    input  logic [31:0]         instr,
    input  logic [31:0]         rs_data,
    input  logic [31:0]         rt_data,
    output logic                legal,
    output logic [NUM_OPS-1:0]  op_sel,
    output logic [31:0]         a,
    output logic [31:0]         b,
    output logic [31:0]         c,
    output logic [4:0]          dest,
    output logic                div_by_zero
);

    logic [5:0]  opcode_s;
    logic [5:0]  funct_s;
    logic [4:0]  shamt_s;
    logic [4:0]  rt_idx_s;
    logic [4:0]  rd_idx_s;
    logic [31:0] imm_sext_s;
    logic [31:0] imm_zext_s;

    assign opcode_s   = instr[31:26];
    assign funct_s    = instr[5:0];
    assign shamt_s    = instr[10:6];
    assign rt_idx_s   = instr[20:16];
    assign rd_idx_s   = instr[15:11];
    assign imm_sext_s = {{16{instr[15]}}, instr[15:0]};
    assign imm_zext_s = {16'h0000, instr[15:0]};

    logic    legal_s;
    op_idx_e op_s;
    logic    shift_s;
    logic    var_shift_s;

    // Instruction decode: selects op, operands and destination
    always_comb begin
        legal_s     = 1'b0;
        op_s        = OP_ADD;
        shift_s     = 1'b0;
        var_shift_s = 1'b0;
        a           = 32'd0;
        b           = 32'd0;
        c           = 32'd0;
        dest        = 5'd0;
        case (opcode_s)
            OPC_RTYPE: begin
                case (funct_s)
                    FN_ADD:  begin legal_s = 1'b1; op_s = OP_ADD;  end
                    FN_ADDU: begin legal_s = 1'b1; op_s = OP_ADDU; end
                    FN_SUB:  begin legal_s = 1'b1; op_s = OP_SUB;  end
                    FN_SUBU: begin legal_s = 1'b1; op_s = OP_SUBU; end
                    FN_AND:  begin legal_s = 1'b1; op_s = OP_AND;  end
                    FN_OR:   begin legal_s = 1'b1; op_s = OP_OR;   end
                    FN_XOR:  begin legal_s = 1'b1; op_s = OP_XOR;  end
                    FN_NOR:  begin legal_s = 1'b1; op_s = OP_NOR;  end
                    FN_MUL:  begin legal_s = 1'b1; op_s = OP_MUL;  end
                    FN_DIV:  begin legal_s = 1'b1; op_s = OP_DIV;  end
                    FN_SLL:  begin legal_s = 1'b1; op_s = OP_SLL; shift_s = 1'b1; end
                    FN_SLA:  begin legal_s = 1'b1; op_s = OP_SLA; shift_s = 1'b1; end
                    FN_SRL:  begin legal_s = 1'b1; op_s = OP_SRL; shift_s = 1'b1; end
                    FN_SRA:  begin legal_s = 1'b1; op_s = OP_SRA; shift_s = 1'b1; end
                    FN_SLLV: begin legal_s = 1'b1; op_s = OP_SLL; shift_s = 1'b1; var_shift_s = 1'b1; end
                    FN_SRLV: begin legal_s = 1'b1; op_s = OP_SRL; shift_s = 1'b1; var_shift_s = 1'b1; end
                    FN_SRAV: begin legal_s = 1'b1; op_s = OP_SRA; shift_s = 1'b1; var_shift_s = 1'b1; end
                    default: begin legal_s = 1'b0; end
                endcase
                if (legal_s) begin
                    dest = rd_idx_s;
                    b    = rt_data;
                    if (shift_s) begin
                        // Shifts take the shifted value on B and the amount on C
                        a = 32'd0;
                        c = var_shift_s ? {27'd0, rs_data[4:0]} : {27'd0, shamt_s};
                    end else begin
                        a = rs_data;
                        c = 32'd0;
                    end
                end else begin
                    dest = 5'd0;
                end
            end
            OPC_ADDI:  begin legal_s = 1'b1; op_s = OP_ADD;  a = rs_data; b = imm_sext_s; dest = rt_idx_s; end
            OPC_ADDIU: begin legal_s = 1'b1; op_s = OP_ADDU; a = rs_data; b = imm_sext_s; dest = rt_idx_s; end
            OPC_ANDI:  begin legal_s = 1'b1; op_s = OP_AND;  a = rs_data; b = imm_zext_s; dest = rt_idx_s; end
            OPC_ORI:   begin legal_s = 1'b1; op_s = OP_OR;   a = rs_data; b = imm_zext_s; dest = rt_idx_s; end
            OPC_XORI:  begin legal_s = 1'b1; op_s = OP_XOR;  a = rs_data; b = imm_zext_s; dest = rt_idx_s; end
            default:   begin legal_s = 1'b0; end
        endcase
    end

    // One-hot select and divide-by-zero flag derived from the decode
    always_comb begin
        legal = legal_s;
        if (legal_s) begin
            op_sel      = op_onehot(op_s);
            div_by_zero = (op_s == OP_DIV) && (b == 32'd0);
        end else begin
            op_sel      = {NUM_OPS{1'b0}};
            div_by_zero = 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: one-entry registered buffer between decode and EX.
// Ports:
//   clk, rst_n          : clock and synchronous active-low reset
//   Flush               : drop the held command and block capture
//   In_Valid/In_Ready   : upstream handshake (In_Ready is combinational)
//   Instr/RS_Data/RT_Data: instruction and source operands
//   Out_Valid/Out_Ready : downstream handshake
//   A, B, C, op selects, ALU_Enable, Dest_Reg, Illegal, Div_By_Zero:
//                         registered decoded command
//   Issue_Count         : wrapping count of accepted instructions
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Flush,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [31:0]      Instr,
    input  logic [31:0]      RS_Data,
    input  logic [31:0]      RT_Data,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [31:0]      A,
    output logic [31:0]      B,
    output logic [31:0]      C,
    output logic             ADD,
    output logic             SUB,
    output logic             ADDu,
    output logic             SUBu,
    output logic             MUL,
    output logic             DIV,
    output logic             AND,
    output logic             OR,
    output logic             XOR,
    output logic             NOR,
    output logic             SRL,
    output logic             SLL,
    output logic             SRA,
    output logic             SLA,
    output logic             ALU_Enable,
    output logic [4:0]       Dest_Reg,
    output logic             Illegal,
    output logic             Div_By_Zero,
    output logic [CNT_W-1:0] Issue_Count
);

    logic               dec_legal_s;
    logic [NUM_OPS-1:0] dec_op_sel_s;
    logic [31:0]        dec_a_s;
    logic [31:0]        dec_b_s;
    logic [31:0]        dec_c_s;
    logic [4:0]         dec_dest_s;
    logic               dec_dbz_s;

    alu_issue_decoder u_decoder (
        .instr       (Instr),
        .rs_data     (RS_Data),
        .rt_data     (RT_Data),
        .legal       (dec_legal_s),
        .op_sel      (dec_op_sel_s),
        .a           (dec_a_s),
        .b           (dec_b_s),
        .c           (dec_c_s),
        .dest        (dec_dest_s),
        .div_by_zero (dec_dbz_s)
    );

    logic               out_valid_r;
    logic [NUM_OPS-1:0] op_sel_r;
    logic               alu_en_r;
    logic               illegal_r;
    logic               dbz_r;
    logic [31:0]        a_r;
    logic [31:0]        b_r;
    logic [31:0]        c_r;
    logic [4:0]         dest_r;
    logic [CNT_W-1:0]   cnt_r;

    logic in_ready_s;
    logic capture_s;

    // Buffer is free when empty or being drained; Flush blocks acceptance
    assign in_ready_s = !Flush && (!out_valid_r || Out_Ready);
    assign capture_s  = In_Valid && in_ready_s;

    // Command register, valid flag and issue counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            op_sel_r    <= {NUM_OPS{1'b0}};
            alu_en_r    <= 1'b0;
            illegal_r   <= 1'b0;
            dbz_r       <= 1'b0;
            a_r         <= 32'd0;
            b_r         <= 32'd0;
            c_r         <= 32'd0;
            dest_r      <= 5'd0;
            cnt_r       <= {CNT_W{1'b0}};
        end else if (Flush) begin
            out_valid_r <= 1'b0;
        end else if (capture_s) begin
            out_valid_r <= 1'b1;
            op_sel_r    <= dec_op_sel_s;
            alu_en_r    <= dec_legal_s;
            illegal_r   <= !dec_legal_s;
            dbz_r       <= dec_dbz_s;
            a_r         <= dec_a_s;
            b_r         <= dec_b_s;
            c_r         <= dec_c_s;
            dest_r      <= dec_dest_s;
            cnt_r       <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (out_valid_r && Out_Ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign In_Ready    = in_ready_s;
    assign Out_Valid   = out_valid_r;
    assign A           = a_r;
    assign B           = b_r;
    assign C           = c_r;
    assign ADD         = op_sel_r[OP_ADD];
    assign SUB         = op_sel_r[OP_SUB];
    assign ADDu        = op_sel_r[OP_ADDU];
    assign SUBu        = op_sel_r[OP_SUBU];
    assign MUL         = op_sel_r[OP_MUL];
    assign DIV         = op_sel_r[OP_DIV];
    assign AND         = op_sel_r[OP_AND];
    assign OR          = op_sel_r[OP_OR];
    assign XOR         = op_sel_r[OP_XOR];
    assign NOR         = op_sel_r[OP_NOR];
    assign SRL         = op_sel_r[OP_SRL];
    assign SLL         = op_sel_r[OP_SLL];
    assign SRA         = op_sel_r[OP_SRA];
    assign SLA         = op_sel_r[OP_SLA];
    assign ALU_Enable  = alu_en_r;
    assign Dest_Reg    = dest_r;
    assign Illegal     = illegal_r;
    assign Div_By_Zero = dbz_r;
    assign Issue_Count = cnt_r;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios followed by
// randomized traffic, all checked against a behavioural reference model.
module tb_alu_issue_stage;

    localparam int CW = 4;  // narrow counter so wrap-around is reached quickly

    logic          clk = 1'b0;
    logic          rst_n, Flush, In_Valid, In_Ready, Out_Valid, Out_Ready;
    logic [31:0]   Instr, RS_Data, RT_Data, A, B, C;
    logic          ADD, SUB, ADDu, SUBu, MUL, DIV, AND, OR, XOR, NOR, SRL, SLL, SRA, SLA;
    logic          ALU_Enable, Illegal, Div_By_Zero;
    logic [4:0]    Dest_Reg;
    logic [CW-1:0] Issue_Count;

    always #5 clk = ~clk;

    alu_issue_stage #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .Flush(Flush), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .Instr(Instr), .RS_Data(RS_Data), .RT_Data(RT_Data),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .A(A), .B(B), .C(C),
        .ADD(ADD), .SUB(SUB), .ADDu(ADDu), .SUBu(SUBu), .MUL(MUL), .DIV(DIV),
        .AND(AND), .OR(OR), .XOR(XOR), .NOR(NOR), .SRL(SRL), .SLL(SLL), .SRA(SRA), .SLA(SLA),
        .ALU_Enable(ALU_Enable), .Dest_Reg(Dest_Reg), .Illegal(Illegal),
        .Div_By_Zero(Div_By_Zero), .Issue_Count(Issue_Count)
    );

    // Bench-side op positions, in port-list order
    localparam int P_ADD = 13, P_SUB = 12, P_ADDU = 11, P_SUBU = 10, P_MUL = 9, P_DIV = 8,
                   P_AND = 7, P_OR = 6, P_XOR = 5, P_NOR = 4, P_SRL = 3, P_SLL = 2,
                   P_SRA = 1, P_SLA = 0;

    wire [13:0] dut_ops = {ADD, SUB, ADDu, SUBu, MUL, DIV, AND, OR, XOR, NOR, SRL, SLL, SRA, SLA};

    typedef struct packed {
        logic [13:0] ops;
        logic        en;
        logic        ill;
        logic        dbz;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [4:0]  dest;
    } cmd_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic          ev;
    cmd_t          held;
    logic [CW-1:0] ecnt;
    logic          zchk;

    function automatic cmd_t ref_decode(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        cmd_t m;
        int p;
        int opc;
        int fn;
        m   = '0;
        p   = -1;
        opc = int'(ins[31:26]);
        fn  = int'(ins[5:0]);
        if (opc == 0) begin
            case (fn)
                'h20: p = P_ADD;  'h21: p = P_ADDU; 'h22: p = P_SUB; 'h23: p = P_SUBU;
                'h24: p = P_AND;  'h25: p = P_OR;   'h26: p = P_XOR; 'h27: p = P_NOR;
                'h18: p = P_MUL;  'h1A: p = P_DIV;
                'h00: p = P_SLL;  'h01: p = P_SLA;  'h02: p = P_SRL; 'h03: p = P_SRA;
                'h04: p = P_SLL;  'h06: p = P_SRL;  'h07: p = P_SRA;
                default: p = -1;
            endcase
            m.a    = rs;
            m.b    = rt;
            m.dest = ins[15:11];
            if (fn <= 3) begin
                m.a = 32'd0;
                m.c = 32'(ins[10:6]);
            end else if (fn == 4 || fn == 6 || fn == 7) begin
                m.a = 32'd0;
                m.c = rs % 32;
            end
        end else begin
            case (opc)
                'h08: begin p = P_ADD;  m.b = {{16{ins[15]}}, ins[15:0]}; end
                'h09: begin p = P_ADDU; m.b = {{16{ins[15]}}, ins[15:0]}; end
                'h0C: begin p = P_AND;  m.b = {16'h0000, ins[15:0]}; end
                'h0D: begin p = P_OR;   m.b = {16'h0000, ins[15:0]}; end
                'h0E: begin p = P_XOR;  m.b = {16'h0000, ins[15:0]}; end
                default: p = -1;
            endcase
            m.a    = rs;
            m.dest = ins[20:16];
        end
        if (p < 0) begin
            m     = '0;
            m.ill = 1'b1;
        end else begin
            m.ops[p] = 1'b1;
            m.en     = 1'b1;
            m.dbz    = (p == P_DIV) && (m.b == 32'd0);
        end
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check outputs of the previous edge, advance model
    task automatic step(input logic r, input logic f, input logic iv, input logic [31:0] ins,
                        input logic [31:0] rs, input logic [31:0] rt, input logic ordy);
        logic exp_rdy;
        @(negedge clk);
        rst_n = r; Flush = f; In_Valid = iv; Instr = ins; RS_Data = rs; RT_Data = rt; Out_Ready = ordy;
        #1;
        exp_rdy = !f && (!ev || ordy);
        chk("in_ready", 32'(In_Ready), 32'(exp_rdy));
        chk("out_valid", 32'(Out_Valid), 32'(ev));
        chk("issue_count", 32'(Issue_Count), 32'(ecnt));
        if (ev || zchk) begin
            chk("op_sel", 32'(dut_ops), 32'(held.ops));
            chk("alu_enable", 32'(ALU_Enable), 32'(held.en));
            chk("illegal", 32'(Illegal), 32'(held.ill));
            chk("div_by_zero", 32'(Div_By_Zero), 32'(held.dbz));
            chk("A", A, held.a);
            chk("B", B, held.b);
            chk("C", C, held.c);
            chk("dest_reg", 32'(Dest_Reg), 32'(held.dest));
        end
        if (!r) begin
            ev = 1'b0; held = '0; ecnt = '0; zchk = 1'b1;
        end else if (f) begin
            ev = 1'b0;
        end else if (iv && exp_rdy) begin
            ev = 1'b1; held = ref_decode(ins, rs, rt); ecnt = ecnt + 1'b1; zchk = 1'b0;
        end else if (ev && ordy) begin
            ev = 1'b0;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0]  rfn [0:16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                    6'h18, 6'h1A, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
        logic [5:0]  ifn [0:4]  = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E};
        logic [31:0] w;
        w = $urandom();
        case ($urandom_range(0, 3))
            0, 1: begin w[31:26] = 6'h00; w[5:0] = rfn[$urandom_range(0, 16)]; end
            2:    w[31:26] = ifn[$urandom_range(0, 4)];
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        logic [31:0] rt_r;
        rst_n = 1'b0; Flush = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b0;
        Instr = 32'd0; RS_Data = 32'd0; RT_Data = 32'd0;
        ev = 1'b0; held = '0; ecnt = '0; zchk = 1'b1;

        // Reset state
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);

        // add $2,$4,$5 with RS=-3, RT=5
        step(1'b1, 1'b0, 1'b1, 32'h00851020, 32'hFFFFFFFD, 32'd5, 1'b1);
        @(posedge clk); #1;
        chk("add_valid", 32'(Out_Valid), 32'd1);
        chk("add_sel", 32'(ADD), 32'd1);
        chk("add_A", A, 32'hFFFFFFFD);
        chk("add_B", B, 32'd5);
        chk("add_dest", 32'(Dest_Reg), 32'd2);
        chk("add_count", 32'(Issue_Count), 32'd1);

        // sra $3,$5,1
        step(1'b1, 1'b0, 1'b1, 32'h00051843, 32'd0, 32'hFFFFFFFD, 1'b1);
        @(posedge clk); #1;
        chk("sra_sel", 32'(SRA), 32'd1);
        chk("sra_C", C, 32'd1);
        chk("sra_dest", 32'(Dest_Reg), 32'd3);

        // addi / andi with imm 0xFFF8
        step(1'b1, 1'b0, 1'b1, 32'h2082FFF8, 32'd4, 32'd0, 1'b1);
        @(posedge clk); #1;
        chk("addi_B", B, 32'hFFFFFFF8);
        step(1'b1, 1'b0, 1'b1, 32'h3082FFF8, 32'd4, 32'd0, 1'b1);
        @(posedge clk); #1;
        chk("andi_sel", 32'(AND), 32'd1);
        chk("andi_B", B, 32'h0000FFF8);

        // Backpressure for three cycles, then simultaneous consume + capture
        step(1'b1, 1'b0, 1'b1, 32'h00A63022, 32'd9, 32'd7, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 32'h00E84024, 32'd1, 32'd2, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h00E84024, 32'd1, 32'd2, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);

        // DIV by zero, then an illegal opcode
        step(1'b1, 1'b0, 1'b1, 32'h0022381A, 32'd100, 32'd0, 1'b1);
        @(posedge clk); #1;
        chk("div_dbz", 32'(Div_By_Zero), 32'd1);
        step(1'b1, 1'b0, 1'b1, 32'hFC000000, 32'd5, 32'd6, 1'b1);
        @(posedge clk); #1;
        chk("illegal_flag", 32'(Illegal), 32'd1);
        chk("illegal_en", 32'(ALU_Enable), 32'd0);
        chk("illegal_valid", 32'(Out_Valid), 32'd1);

        // Flush with held command and incoming instruction
        step(1'b1, 1'b1, 1'b1, 32'h00851020, 32'd1, 32'd1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);

        // Reset in the middle of a stall
        step(1'b1, 1'b0, 1'b1, 32'h00851021, 32'd3, 32'd4, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h00851021, 32'd3, 32'd4, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h00851021, 32'd3, 32'd4, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);

        // Randomized traffic (counter wraps several times)
        for (int i = 0; i < 500; i++) begin
            rt_r = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 3) != 0), rand_instr(), $urandom(), rt_r,
                 ($urandom_range(0, 3) != 0));
        end
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
